// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte buffer and load sequencer sitting directly upstream of the UART
// transmitter. Bytes arrive over a valid/ready interface into a FIFO. The
// sequencer hands one byte at a time to the transmitter: it registers the FIFO
// head into uart_din, pulses uart_wr for one cycle, and then waits for the
// transmitter's TE flag to fall and rise again before it offers the next byte.
//
// Ports
//   clk        : system clock, rising edge
//   resetn     : synchronous active-low reset
//   s_data     : producer byte
//   s_valid    : producer byte valid
//   s_ready    : FIFO can accept a byte this cycle
//   flush      : synchronous FIFO clear; the byte already loaded is unaffected
//   TE         : transmitter empty flag (1 = idle, may load)
//   uart_din   : byte presented to the transmitter
//   uart_wr    : one-cycle load strobe to the transmitter
//   fifo_count : bytes held in the FIFO, 0..DEPTH
//   busy       : FIFO non-empty or sequencer not idle
module uart_tx_feeder #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    input  logic              TE,
    output logic [7:0]        uart_din,
    output logic              uart_wr,
    output logic [ADDR_W:0]   fifo_count,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_COUNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    logic [7:0]        r_din;
    logic              r_wr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Readiness depends only on the registered count plus flush/reset, so a
    // pop in the same cycle never opens a slot in a full FIFO.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == {(ADDR_W + 1){1'b0}});
    assign s_ready = !w_full && !flush && resetn;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty && TE;

    assign uart_din   = r_din;
    assign uart_wr    = r_wr;
    assign fifo_count = r_count;
    assign busy       = !w_empty || (r_state != ST_IDLE);

    // FIFO storage; writes only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; flush clears them and drops a concurrent push.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= {ADDR_W{1'b0}};
            r_rd_ptr <= {ADDR_W{1'b0}};
            r_count  <= {(ADDR_W + 1){1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {ADDR_W{1'b0}};
            r_rd_ptr <= {ADDR_W{1'b0}};
            r_count  <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_COUNT;
                2'b01:   r_count <= r_count - ONE_COUNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Load sequencer: pop into uart_din, strobe once, then track TE busy/idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_din   <= 8'h00;
            r_wr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_din   <= r_mem[r_rd_ptr];
                        r_wr    <= 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_wr    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_wr    <= 1'b0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    r_wr <= 1'b0;
                    if (!TE) begin
                        r_state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    r_wr <= 1'b0;
                    if (TE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_wr    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
